// File: rtl/seg_scan_controller.sv
// Two-digit multiplexed seven-segment scanner: shows the synchronized write-block
// select on the right digit and the read-block select on the left, with dark gaps between digits.
module seg_scan_controller #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       switch0,
    input  logic       switch1,
    output logic       a0,
    output logic       a1,
    output logic [6:0] cathode,
    output logic       slot_tick
);

    localparam int CW          = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int SHOW_CYCLES = REFRESH_DIV - BLANK_CYCLES;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [6:0]    DARK       = 7'b1111111;

    typedef enum logic [1:0] {BLANK_R, SHOW_R, BLANK_L, SHOW_L} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          last;
    logic [1:0]    sw_meta, sw_sync;
    logic          dig_r, dig_l;
    logic          a0_next, a1_next, tick_next;
    logic [6:0]    cathode_next;

    function automatic logic [6:0] glyph(input logic blk);
        return blk ? 7'b0010010 : 7'b1001111;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; the async reset branch also darkens the outputs instantly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= BLANK_R;
            cnt       <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
            dig_r     <= 1'b0;
            dig_l     <= 1'b0;
            a0        <= 1'b1;
            a1        <= 1'b1;
            cathode   <= DARK;
            slot_tick <= 1'b0;
        end else begin
            sw_meta   <= {switch1, switch0};
            sw_sync   <= sw_meta;
            state     <= state_next;
            cnt       <= cnt_next;
            a0        <= a0_next;
            a1        <= a1_next;
            cathode   <= cathode_next;
            slot_tick <= tick_next;
            // Digit values freeze on the BLANK->SHOW edge and hold through the SHOW.
            if (enable && last && state == BLANK_R) dig_r <= sw_sync[0];
            if (enable && last && state == BLANK_L) dig_l <= sw_sync[1];
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 1'b1;
        a0_next      = 1'b1;
        a1_next      = 1'b1;
        cathode_next = DARK;
        tick_next    = 1'b0;
        last         = (state == SHOW_R || state == SHOW_L) ? (cnt == SHOW_LAST)
                                                            : (cnt == BLANK_LAST);

        if (!enable) begin
            state_next = BLANK_R;
            cnt_next   = '0;
        end else begin
            if (last) begin
                cnt_next = '0;
                unique case (state)
                    BLANK_R: state_next = SHOW_R;
                    SHOW_R:  state_next = BLANK_L;
                    BLANK_L: state_next = SHOW_L;
                    SHOW_L:  state_next = BLANK_R;
                    default: state_next = BLANK_R;
                endcase
            end

            // Outputs register the decode of the current slot, one clock behind the state.
            unique case (state)
                SHOW_R: begin
                    a0_next      = 1'b0;
                    cathode_next = glyph(dig_r);
                    tick_next    = last;
                end
                SHOW_L: begin
                    a1_next      = 1'b0;
                    cathode_next = glyph(dig_l);
                    tick_next    = last;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller at REFRESH_DIV=8, BLANK_CYCLES=2:
// hand-tabled first scan plus a slot-position model for every sampled cycle.
module tb_seg_scan_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       switch0;
    logic       switch1;
    logic       a0;
    logic       a1;
    logic [6:0] cathode;
    logic       slot_tick;

    seg_scan_controller #(
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .switch0  (switch0),
        .switch1  (switch1),
        .a0       (a0),
        .a1       (a1),
        .cathode  (cathode),
        .slot_tick(slot_tick)
    );

    always #5 clock = ~clock;

    localparam logic [9:0] DARK_V = 10'b11_0_1111111;

    int passed = 0;
    int total  = 0;
    int both_low = 0;

    // Scan model: slot position within the 16-cycle period plus a 2-stage switch pipe.
    int   pos;
    logic s1_0, s2_0, s1_1, s2_1;
    logic dr, dl;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        if (obs !== exp)
            $display("FAIL %s @%0t: got %b expected %b", tag, $time, obs, exp);
        else
            passed++;
    endtask

    function automatic logic [6:0] glyph(input logic blk);
        return blk ? 7'b0010010 : 7'b1001111;
    endfunction

    // Hand-computed first scan after reset with switch0=0, switch1=1.
    function automatic logic [9:0] hand_first_scan(input int n);
        if (n == 1 || n == 2 || n == 9 || n == 10) return DARK_V;
        if (n >= 3 && n <= 7)   return 10'b10_0_1001111;
        if (n == 8)             return 10'b10_1_1001111;
        if (n >= 11 && n <= 15) return 10'b01_0_0010010;
        return 10'b01_1_0010010;
    endfunction

    function automatic logic [9:0] obs_vec();
        return {a1, a0, slot_tick, cathode};
    endfunction

    task automatic model_reset();
        pos = 0;
        s1_0 = 1'b0; s2_0 = 1'b0;
        s1_1 = 1'b0; s2_1 = 1'b0;
        dr = 1'b0; dl = 1'b0;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then check #1 later.
    task automatic cyc();
        logic [9:0] exp;
        @(posedge clock);
        exp = DARK_V;
        if (!enable) begin
            pos = 0;
        end else begin
            if (pos >= 2 && pos <= 7)
                exp = {2'b10, pos == 7, glyph(dr)};
            else if (pos >= 10 && pos <= 15)
                exp = {2'b01, pos == 15, glyph(dl)};
            if (pos == 1) dr = s2_0;
            if (pos == 9) dl = s2_1;
            pos = (pos + 1) % 16;
        end
        s2_0 = s1_0; s1_0 = switch0;
        s2_1 = s1_1; s1_1 = switch1;
        #1;
        check("scan", obs_vec(), exp);
        if (!a0 && !a1) both_low++;
    endtask

    // Hold reset across two edges, then release mid-cycle so the next edge is cycle 1.
    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        switch0 = 1'b0;
        switch1 = 1'b1;
        model_reset();
        #2;
        check("reset_outputs", obs_vec(), DARK_V);

        // First scan against the hand table; switch0 flips inside SHOW_R (cycle 4).
        do_reset();
        for (int n = 1; n <= 32; n++) begin
            cyc();
            if (n <= 16) check("first_scan", obs_vec(), hand_first_scan(n));
            if (n == 4) switch0 = 1'b1;
        end

        // Enable dropped after cycle 12, raised again after cycle 16.
        switch0 = 1'b0;
        switch1 = 1'b1;
        do_reset();
        for (int n = 1; n <= 24; n++) begin
            cyc();
            if (n == 12) enable = 1'b0;
            if (n == 16) enable = 1'b1;
        end

        // Asynchronous reset in the middle of SHOW_L, then the first scan must repeat.
        do_reset();
        for (int n = 1; n <= 12; n++) cyc();
        #2 reset = 1'b1;
        #1 check("async_reset_dark", obs_vec(), DARK_V);
        model_reset();
        @(posedge clock);
        #1 check("reset_held", obs_vec(), DARK_V);
        #2 reset = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            cyc();
            check("scan_after_reset", obs_vec(), hand_first_scan(n));
        end

        // Random switch activity: the model tracks the latched digits and exact slot lengths.
        for (int n = 0; n < 10000; n++) begin
            cyc();
            if ($urandom_range(0, 3) == 0) switch0 = ~switch0;
            if ($urandom_range(0, 3) == 0) switch1 = ~switch1;
        end

        check("both_anodes_low", {9'd0, both_low != 0}, 10'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
